// File: rtl/cal_pkg.sv
// Shared widths, field limits and handshake FSM states for the time-of-day and calendar stages.
package cal_pkg;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    typedef enum logic {
        TOD_IDLE = 1'b0,
        TOD_ACK  = 1'b1
    } tod_state_t;

    function automatic logic time_in_range(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m,
        input logic [SEC_W-1:0]  s
    );
        return (h <= HOUR_W'(MAX_HOUR)) && (m <= MIN_W'(MAX_MIN)) && (s <= SEC_W'(MAX_SEC));
    endfunction
endpackage

// File: rtl/tod_counter_if.sv
// Valid/ready load port carrying a new hh:mm:ss and the range-error response.
interface tod_counter_if;
    import cal_pkg::*;

    logic              set_valid;
    logic              set_ready;
    logic [HOUR_W-1:0] set_hour;
    logic [MIN_W-1:0]  set_min;
    logic [SEC_W-1:0]  set_sec;
    logic              set_err;

    modport master (
        output set_valid, set_hour, set_min, set_sec,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hour, set_min, set_sec,
        output set_ready, set_err
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with load priority and a combinational carry into the next field.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         carry
);
    logic [W-1:0] r_value;
    logic         w_at_max;

    assign w_at_max = (r_value == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            r_value <= w_at_max ? '0 : r_value + 1'b1;
        end
    end

    assign value = r_value;
    assign carry = inc && w_at_max;
endmodule

// File: rtl/tod_counter.sv
// hh:mm:ss counter advanced by a prescaler, with a valid/ready range-checked load port.
module tod_counter
    import cal_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    tod_counter_if.slave      set_bus,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic              sec_tick,
    output logic              day_tick
);
    localparam int PRE_W = $clog2(TICKS_PER_SEC);

    tod_state_t r_state;
    tod_state_t w_next_state;

    logic [PRE_W-1:0] r_pre;
    logic             r_sec_tick;
    logic             r_day_tick;
    logic             r_set_err;

    logic w_accept;
    logic w_in_range;
    logic w_load;
    logic w_term;
    logic w_adv;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hour_carry;

    assign w_accept   = (r_state == TOD_IDLE) && set_bus.set_valid;
    assign w_in_range = time_in_range(set_bus.set_hour, set_bus.set_min, set_bus.set_sec);
    assign w_load     = w_accept && w_in_range;
    assign w_term     = run_en && (r_pre == PRE_W'(TICKS_PER_SEC - 1));
    // A valid load on the terminal-count edge swallows that second's advance.
    assign w_adv      = w_term && !w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TOD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TOD_IDLE: if (set_bus.set_valid) w_next_state = TOD_ACK;
            TOD_ACK:  w_next_state = TOD_IDLE;
            default:  w_next_state = TOD_IDLE;
        endcase
    end

    always_comb begin
        set_bus.set_ready = (r_state == TOD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_load || w_term) begin
            r_pre <= '0;
        end else if (run_en) begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= w_adv;
            r_day_tick <= w_hour_carry;
            r_set_err  <= w_accept && !w_in_range;
        end
    end

    mod_counter #(.W(SEC_W), .MAX(MAX_SEC)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_adv),
        .load     (w_load),
        .load_val (set_bus.set_sec),
        .value    (sec),
        .carry    (w_sec_carry)
    );

    mod_counter #(.W(MIN_W), .MAX(MAX_MIN)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_sec_carry),
        .load     (w_load),
        .load_val (set_bus.set_min),
        .value    (min),
        .carry    (w_min_carry)
    );

    mod_counter #(.W(HOUR_W), .MAX(MAX_HOUR)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_min_carry),
        .load     (w_load),
        .load_val (set_bus.set_hour),
        .value    (hour),
        .carry    (w_hour_carry)
    );

    assign sec_tick        = r_sec_tick;
    assign day_tick        = r_day_tick;
    assign set_bus.set_err = r_set_err;
endmodule

// File: tb/tb_tod_counter.sv
// Directed bench for tod_counter at four clocks per second: vector table plus hand-written corner sequences.
module tb_tod_counter;
    localparam int TICKS = 4;

    typedef struct {
        logic run_en;
        logic valid;
        int   h, m, s;
        int   eh, em, es;
        logic e_tick, e_day, e_ready, e_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic       day_tick;

    int errors = 0;
    int checks = 0;

    vec_t vecs[12];

    tod_counter_if set_if ();

    tod_counter #(.TICKS_PER_SEC(TICKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_en   (run_en),
        .set_bus  (set_if),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic re, input logic v, input int h, input int m, input int s,
                                   input int eh, input int em, input int es,
                                   input logic t, input logic d, input logic r, input logic e);
        vec_t x;
        x.run_en = re; x.valid = v; x.h = h; x.m = m; x.s = s;
        x.eh = eh; x.em = em; x.es = es;
        x.e_tick = t; x.e_day = d; x.e_ready = r; x.e_err = e;
        return x;
    endfunction

    task automatic applyStimulus(input logic re, input logic v, input int h, input int m, input int s);
        run_en            = re;
        set_if.set_valid  = v;
        set_if.set_hour   = 5'(h);
        set_if.set_min    = 6'(m);
        set_if.set_sec    = 6'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int eh, input int em, input int es,
                               input logic t, input logic d, input logic r, input logic e);
        checks++;
        if (int'(hour) != eh || int'(min) != em || int'(sec) != es || sec_tick !== t ||
            day_tick !== d || set_if.set_ready !== r || set_if.set_err !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %0d:%0d:%0d tick=%0b day=%0b ready=%0b err=%0b, expected %0d:%0d:%0d tick=%0b day=%0b ready=%0b err=%0b",
                     name, hour, min, sec, sec_tick, day_tick, set_if.set_ready, set_if.set_err,
                     eh, em, es, t, d, r, e);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        run_en            = 1'b0;
        set_if.set_valid  = 1'b0;
        set_if.set_hour   = '0;
        set_if.set_min    = '0;
        set_if.set_sec    = '0;

        // Free-running seconds: one advance every fourth edge after reset.
        vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        vecs[4]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[5]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[6]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[7]  = mkVec(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0);
        vecs[8]  = mkVec(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
        vecs[9]  = mkVec(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
        vecs[10] = mkVec(1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
        vecs[11] = mkVec(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0);

        resetDut();
        checkOutput("reset_state", 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].run_en, vecs[i].valid, vecs[i].h, vecs[i].m, vecs[i].s);
            checkOutput($sformatf("run_vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es,
                        vecs[i].e_tick, vecs[i].e_day, vecs[i].e_ready, vecs[i].e_err);
        end

        // Day rollover from 23:59:59.
        applyStimulus(1, 1, 23, 59, 59);
        checkOutput("load_235959", 23, 59, 59, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("pre_roll%0d", i), 23, 59, 59, 0, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("day_rollover", 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post_rollover", 0, 0, 0, 0, 0, 1, 0);

        // Hour carry without a day tick, then a 00:00:00 load that is not a rollover.
        resetDut();
        applyStimulus(1, 1, 9, 59, 59);
        checkOutput("load_095959", 9, 59, 59, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("hour_carry", 10, 0, 0, 1, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("load_zero_no_day", 0, 0, 0, 0, 0, 0, 0);

        // Out-of-range loads.
        resetDut();
        applyStimulus(1, 1, 24, 0, 0);
        checkOutput("bad_hour_err", 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("bad_hour_after", 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 60);
        checkOutput("bad_sec_err", 0, 0, 0, 0, 0, 0, 1);

        // Load on the terminal-count edge wins over the advance.
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 10, 20, 30);
        checkOutput("load_on_tc", 10, 20, 30, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("after_tc_load%0d", i), 10, 20, 30, 0, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("full_second_after_load", 10, 20, 31, 1, 0, 1, 0);

        // Freeze with run_en low; prescaler must resume where it stopped.
        resetDut();
        applyStimulus(1, 1, 12, 0, 0);
        checkOutput("load_120000", 12, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("frozen%0d", i), 12, 0, 0, 0, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resume_no_tick", 12, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("resume_tick", 12, 0, 1, 1, 0, 1, 0);
        applyStimulus(0, 1, 1, 2, 3);
        checkOutput("load_while_frozen", 1, 2, 3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("frozen_after_load", 1, 2, 3, 0, 0, 1, 0);

        // Reset during ACK with the prescaler at terminal count and a load held.
        resetDut();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 24, 0, 0);
        checkOutput("ack_before_reset", 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        applyStimulus(1, 1, 5, 6, 7);
        checkOutput("mid_ack_reset", 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("post_reset%0d", i), 0, 0, 0, 0, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post_reset_tick", 0, 0, 1, 1, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
